// File: rtl/vx_dispatch_lane_splitter.sv
// vx_dispatch_lane_splitter
//   Takes one full-warp dispatch packet (NUM_THREADS lanes) and replays it
//   to a narrower execute unit as NUM_PACKETS = NUM_THREADS/NUM_LANES
//   lane-batch packets. Each packet is tagged with pid, sop and eop. Exactly
//   one instruction is held. A new instruction is accepted in the same cycle
//   that the last packet of the held one fires, so issue has no bubbles.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : dispatch handshake
//   in_meta               : opaque sideband, held and repeated on every packet
//   in_tmask, in_rs*_data : full-warp mask/operands, thread t at [t*XLEN +: XLEN]
//   out_valid / out_ready : lane-packet handshake
//   out_meta, out_tmask, out_rs*_data : held sideband plus the slice picked by pid
//   out_pid, out_sop, out_eop         : packet index, first/last emitted packet
//
// Optional feature: define DISPATCH_SKIP_EMPTY_EN to skip packets whose mask
// slice is all zero. An all-zero mask then emits only pid 0. When the macro is
// undefined, every packet is emitted.
module vx_dispatch_lane_splitter #(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_LANES   = 2,
  parameter  int XLEN        = 32,
  parameter  int META_W      = 64,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [META_W-1:0]           in_meta,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [META_W-1:0]           out_meta,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
  output logic [PID_W-1:0]            out_pid,
  output logic                        out_sop,
  output logic                        out_eop
);

  localparam int SLICE_W = NUM_LANES * XLEN;

  if (NUM_LANES < 1 || (NUM_THREADS % NUM_LANES) != 0) begin : g_bad_cfg
    $error("vx_dispatch_lane_splitter: NUM_LANES must divide NUM_THREADS");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                   state;
  logic [PID_W-1:0]                         pid_q;
  logic [META_W-1:0]                        meta_q;
  // Held operands are stored in packet-major form, so a slice is one index.
  logic [NUM_PACKETS-1:0][NUM_LANES-1:0]    tm_q;
  logic [NUM_PACKETS-1:0][SLICE_W-1:0]      rs1_q, rs2_q, rs3_q;

  logic [PID_W-1:0] first_in_pid;  // first packet of the instruction being accepted
  logic [PID_W-1:0] first_pid;     // first/last/next packet of the held instruction
  logic [PID_W-1:0] last_pid;
  logic [PID_W-1:0] next_pid;

`ifdef DISPATCH_SKIP_EMPTY_EN
  function automatic logic [NUM_PACKETS-1:0] nz_of(
      input logic [NUM_PACKETS-1:0][NUM_LANES-1:0] m);
    nz_of = '0;
    for (int p = 0; p < NUM_PACKETS; p++) nz_of[p] = |m[p];
  endfunction

  // With no live slice at all, pid 0 stands in as both first and last packet.
  function automatic logic [PID_W-1:0] first_of(input logic [NUM_PACKETS-1:0] nz);
    first_of = '0;
    for (int p = NUM_PACKETS - 1; p >= 0; p--) if (nz[p]) first_of = PID_W'(p);
  endfunction

  function automatic logic [PID_W-1:0] last_of(input logic [NUM_PACKETS-1:0] nz);
    last_of = '0;
    for (int p = 0; p < NUM_PACKETS; p++) if (nz[p]) last_of = PID_W'(p);
  endfunction

  function automatic logic [PID_W-1:0] next_of(input logic [NUM_PACKETS-1:0] nz,
                                               input logic [PID_W-1:0]       cur);
    next_of = cur;
    for (int p = NUM_PACKETS - 1; p >= 0; p--)
      if (nz[p] && p > int'(cur)) next_of = PID_W'(p);
  endfunction

  logic [NUM_PACKETS-1:0] in_nz, held_nz;
  assign in_nz        = nz_of(in_tmask);
  assign held_nz      = nz_of(tm_q);
  assign first_in_pid = first_of(in_nz);
  assign first_pid    = first_of(held_nz);
  assign last_pid     = last_of(held_nz);
  assign next_pid     = next_of(held_nz, pid_q);
`else
  assign first_in_pid = '0;
  assign first_pid    = '0;
  assign last_pid     = PID_W'(NUM_PACKETS - 1);
  assign next_pid     = pid_q + PID_W'(1);
`endif

  logic in_fire, out_fire;

  assign out_valid = (state == SEND);
  assign out_pid   = pid_q;
  assign out_sop   = (pid_q == first_pid);
  assign out_eop   = (pid_q == last_pid);
  assign out_fire  = out_valid && out_ready;
  // Refill in the same cycle that the last packet fires: the out_ready -> in_ready path is intentional.
  assign in_ready  = (state == IDLE) || (out_fire && out_eop);
  assign in_fire   = in_valid && in_ready;

  assign out_meta     = meta_q;
  assign out_tmask    = tm_q[pid_q];
  assign out_rs1_data = rs1_q[pid_q];
  assign out_rs2_data = rs2_q[pid_q];
  assign out_rs3_data = rs3_q[pid_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pid_q <= '0;
    end else if (in_fire) begin
      state  <= SEND;
      pid_q  <= first_in_pid;
      meta_q <= in_meta;
      tm_q   <= in_tmask;
      rs1_q  <= in_rs1_data;
      rs2_q  <= in_rs2_data;
      rs3_q  <= in_rs3_data;
    end else if (out_fire) begin
      if (out_eop) state <= IDLE;
      else         pid_q <= next_pid;
    end
  end

endmodule
